// File: rtl/ysyx_22040237_ifu.sv
// rtl/ysyx_22040237_ifu.sv - NPC instruction fetch unit
// Single-outstanding fetch FSM: owns the PC and applies decode's JAL redirect and ebreak halt.
module ysyx_22040237_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        jump_flag,
  input  logic [31:0] jump_off,
  input  logic        halt_req,
  output logic        halted,
  output logic        fetch_err,
  output logic [63:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_VALID, S_HALT, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] next_pc;
  logic        fire;
  logic        resp_take;
  logic        next_misaligned;

  assign fire            = (state == S_VALID) && out_ready;
  assign resp_take       = (state == S_WAIT) && imem_resp_valid;
  assign next_pc         = pc + (jump_flag ? jump_off : 32'd4);
  assign next_misaligned = (next_pc[1:0] != 2'b00);

  assign imem_req_addr = pc;
  assign out_pc        = pc;
  assign out_inst      = inst;

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) state_nxt = imem_resp_err ? S_ERR : S_VALID;
      end
      S_VALID: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (halt_req)             state_nxt = S_HALT;
          else if (next_misaligned) state_nxt = S_ERR;
          else                      state_nxt = S_REQ;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
      inst_cnt  <= 64'h0;
    end else begin
      state <= state_nxt;
      if (resp_take) begin
        if (imem_resp_err) fetch_err <= 1'b1;
        else               inst      <= imem_resp_data;
      end
      if (fire) begin
        inst_cnt <= inst_cnt + 64'd1;
        if (halt_req) begin
          halted <= 1'b1;
        end else begin
          // A misaligned target is still loaded so the faulting PC is visible.
          pc <= next_pc;
          if (next_misaligned) fetch_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// tb/tb_ysyx_22040237_ifu.sv - directed vector bench for the fetch unit
// Memory model answers one cycle after each accepted request.
module tb_ysyx_22040237_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_off = 32'h0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        fetch_err;
  logic [63:0] inst_cnt;

  ysyx_22040237_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .jump_flag(jump_flag), .jump_off(jump_off), .halt_req(halt_req),
    .halted(halted), .fetch_err(fetch_err), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic        pending = 1'b0;
  logic [31:0] paddr   = 32'h0;
  logic        stray   = 1'b0;
  logic        err_inj = 1'b0;

  typedef struct packed {
    logic        jf;
    logic [31:0] off;
    logic [31:0] pc;
    logic [31:0] nxt;
  } vec_t;

  vec_t vt [8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8010_0093;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive the memory response, cross the posedge, return at negedge.
  task automatic tick();
    logic        acc;
    logic [31:0] aaddr;
    imem_resp_valid = pending | stray;
    imem_resp_data  = pending ? mem_word(paddr) : 32'hDEAD_BEEF;
    imem_resp_err   = pending & err_inj;
    acc   = imem_req_valid & imem_req_ready;
    aaddr = imem_req_addr;
    @(posedge clk);
    pending = acc;
    paddr   = aaddr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    pending = 1'b0;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr",  imem_req_addr, RST_PC);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc",    out_pc, RST_PC);
    chk("rst_out_inst",  out_inst, 32'h0);
    chk("rst_halted",    halted, 1'b0);
    chk("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_inst_cnt",  inst_cnt, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", imem_req_valid, 1'b0);
    tick();
    chk("req_after_idle", imem_req_valid, 1'b1);
  endtask

  // From REQ at pc: fetch, present, and accept with the given jump inputs.
  task automatic fetch_accept(input logic [31:0] pc, input logic jf, input logic [31:0] off,
                              input logic hr);
    chk("req_addr", imem_req_addr, pc);
    tick();
    chk("wait_no_out", out_valid, 1'b0);
    tick();
    chk("out_valid", out_valid, 1'b1);
    chk("out_pc", out_pc, pc);
    chk("out_inst", out_inst, mem_word(pc));
    out_ready = 1'b1; jump_flag = jf; jump_off = off; halt_req = hr;
    tick();
    out_ready = 1'b0; jump_flag = 1'b0; jump_off = 32'h0; halt_req = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 32'h0,         32'h8000_0000, 32'h8000_0004};
    vt[1] = '{1'b0, 32'h0,         32'h8000_0004, 32'h8000_0008};
    vt[2] = '{1'b0, 32'h0,         32'h8000_0008, 32'h8000_000C};
    vt[3] = '{1'b0, 32'h0,         32'h8000_000C, 32'h8000_0010};
    vt[4] = '{1'b1, 32'h0,         32'h8000_0010, 32'h8000_0010};
    vt[5] = '{1'b1, 32'hFFFF_FFF8, 32'h8000_0010, 32'h8000_0008};
    vt[6] = '{1'b1, 32'h0000_0100, 32'h8000_0008, 32'h8000_0108};
    vt[7] = '{1'b1, 32'hFFFF_FEF8, 32'h8000_0108, 32'h8000_0000};

    @(negedge clk);
    do_reset();
    chk("first_inst", mem_word(RST_PC), 32'h0010_0093);

    for (int i = 0; i < 8; i++) begin
      fetch_accept(vt[i].pc, vt[i].jf, vt[i].off, 1'b0);
      chk("cnt_after_hs", inst_cnt, 64'(i + 1));
      chk("next_req_valid", imem_req_valid, 1'b1);
      chk("next_req_addr", imem_req_addr, vt[i].nxt);
    end

    // Request backpressure: address held, nothing accepted.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_req_valid", imem_req_valid, 1'b1);
      chk("bp_req_addr", imem_req_addr, RST_PC);
      chk("bp_no_pending", pending, 1'b0);
    end
    imem_req_ready = 1'b1;
    tick();
    tick();
    chk("bp_out_valid", out_valid, 1'b1);
    // Output backpressure with noise on ignored inputs and a stray response.
    jump_flag = 1'b1; jump_off = 32'h2; halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stray = (i == 2);
      tick();
      chk("ob_out_valid", out_valid, 1'b1);
      chk("ob_out_pc", out_pc, RST_PC);
      chk("ob_out_inst", out_inst, mem_word(RST_PC));
      chk("ob_inst_cnt", inst_cnt, 64'd8);
      chk("ob_fetch_err", fetch_err, 1'b0);
    end
    stray = 1'b0; jump_flag = 1'b0; jump_off = 32'h0; halt_req = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ob_cnt_after", inst_cnt, 64'd9);
    chk("ob_next_addr", imem_req_addr, 32'h8000_0004);

    // Halt on ebreak.
    fetch_accept(32'h8000_0004, 1'b1, 32'h40, 1'b1);
    chk("halt_flag", halted, 1'b1);
    chk("halt_cnt", inst_cnt, 64'd10);
    chk("halt_pc_kept", imem_req_addr, 32'h8000_0004);
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (imem_req_valid || out_valid) bad++;
      end
      chk("halt_quiet", bad, 0);
    end

    // Async reset asserted mid-WAIT, away from any clock edge.
    do_reset();
    tick();
    chk("wait_state_no_out", out_valid, 1'b0);
    #2;
    do_reset();
    fetch_accept(RST_PC, 1'b0, 32'h0, 1'b0);
    chk("restart_cnt", inst_cnt, 64'd1);
    chk("restart_next", imem_req_addr, 32'h8000_0004);

    // Access fault on the response.
    do_reset();
    err_inj = 1'b1;
    tick();
    tick();
    err_inj = 1'b0;
    chk("err_flag", fetch_err, 1'b1);
    chk("err_no_out", out_valid, 1'b0);
    begin
      int bad = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (imem_req_valid || out_valid) bad++;
      end
      chk("err_quiet", bad, 0);
    end

    // Misaligned jump target.
    do_reset();
    fetch_accept(RST_PC, 1'b1, 32'h2, 1'b0);
    chk("mis_flag", fetch_err, 1'b1);
    chk("mis_no_req", imem_req_valid, 1'b0);
    chk("mis_pc", imem_req_addr, 32'h8000_0002);
    chk("mis_cnt", inst_cnt, 64'd1);
    tick();
    chk("mis_still_no_req", imem_req_valid, 1'b0);
    chk("mis_halted_clear", halted, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
